// File: rtl/ram_master_pkg.sv
// rtl/ram_master_pkg.sv - widths and FSM state type shared by ram_master
package ram_master_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ISSUE,
        RD_CAPTURE,
        RD_RESP
    } state_t;

endpackage

// File: rtl/ram_master.sv
// rtl/ram_master.sv - request-to-sync-RAM master; read bursts enabled by RAM_MASTER_BURST_EN
module ram_master
    import ram_master_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LEN_W-1:0]  req_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_last,
    output logic              busy,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t state_q;
    state_t state_n;

    logic accept;
    logic handshake;
    logic more_beats;
    logic last_beat;

    // req_ready is only ever high in IDLE, so accept implies IDLE
    assign accept    = req_valid && req_ready;
    assign handshake = rsp_valid && rsp_ready;
    assign busy      = (state_q != IDLE);

`ifdef RAM_MASTER_BURST_EN
    logic [LEN_W-1:0] beat_q;
    logic [LEN_W-1:0] len_q;

    // beat counter: cleared on accept, advanced on each consumed non-final beat
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q <= '0;
            len_q  <= '0;
        end else if (state_q == IDLE && accept) begin
            beat_q <= '0;
            len_q  <= req_len;
        end else if (state_q == RD_RESP && handshake && more_beats) begin
            beat_q <= beat_q + 1'b1;
        end
    end

    assign more_beats = (beat_q != len_q);
    assign last_beat  = (beat_q == len_q);
`else
    // single-beat reads only; the length field has no effect
    logic unused_len;
    assign unused_len = ^req_len;
    assign more_beats = 1'b0;
    assign last_beat  = 1'b1;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // next-state logic
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_n = req_write ? WRITE : RD_ISSUE;
                end
            end
            WRITE:      state_n = IDLE;
            RD_ISSUE:   state_n = RD_CAPTURE;
            RD_CAPTURE: state_n = RD_RESP;
            RD_RESP: begin
                if (handshake) begin
                    state_n = more_beats ? RD_ISSUE : IDLE;
                end
            end
            default:    state_n = IDLE;
        endcase
    end

    // registered outputs: RAM side loaded on accept, response loaded at capture
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready <= 1'b0;
            ram_en    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_last  <= 1'b0;
        end else begin
            req_ready <= (state_n == IDLE);
            ram_en    <= (state_n == WRITE);
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ram_addr  <= req_addr;
                        ram_wdata <= req_wdata;
                    end
                end
                RD_CAPTURE: begin
                    rsp_rdata <= ram_rdata;
                    rsp_valid <= 1'b1;
                    rsp_last  <= last_beat;
                end
                RD_RESP: begin
                    if (handshake) begin
                        rsp_valid <= 1'b0;
                        rsp_last  <= 1'b0;
                        if (more_beats) begin
                            ram_addr <= ram_addr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ram_master.md
RAM_MASTER -- requirements
Module: ram_master

Interface
REQ-001 The block SHALL have these ports, one clock domain, in this order:
- clk  in  1  rising-edge clock; sole clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  8  start address.
- req_wdata  in  8  write data; single beat only.
- req_len  in  4  read burst beats minus 1 (0..15).
- rsp_valid  out  1  read data present.
- rsp_ready  in  1  consumer accepts read data.
- rsp_rdata  out  8  read data.
- rsp_last  out  1  final beat of a read burst.
- busy  out  1  high whenever state is not IDLE.
- ram_en  out  1  RAM write strobe.
- ram_addr  out  8  RAM address.
- ram_wdata  out  8  RAM write data.
- ram_rdata  in  8  RAM read data.
REQ-002 RAM contract: write occurs at a clk edge when ram_en=1; ram_rdata returns the word at ram_addr with 1-cycle synchronous latency.

Function
REQ-003 Request handshake SHALL complete on an edge where req_valid & req_ready; req_ready=1 only in IDLE.
REQ-004 The FSM SHALL have states IDLE, WRITE, RD_ISSUE, RD_CAPTURE, RD_RESP.
REQ-005 IDLE -> WRITE on an accepted write; IDLE -> RD_ISSUE on an accepted read.
REQ-006 All RAM-side outputs SHALL be registers loaded on the accepting edge.
REQ-007 In WRITE: ram_en=1 for exactly one cycle, with ram_addr=req_addr and ram_wdata=req_wdata; then -> IDLE. Writes SHALL produce no response.
REQ-008 ram_en SHALL be 0 in every state other than WRITE.
REQ-009 Read sequence:
- RD_ISSUE (1 cycle) -> RD_CAPTURE (1 cycle).
- At the end of RD_CAPTURE: rsp_rdata <= ram_rdata, rsp_valid <= 1; -> RD_RESP.
REQ-010 rsp_valid SHALL first be high in the third cycle after the accepting edge; rsp_rdata and rsp_last SHALL stay stable while rsp_valid & !rsp_ready.
REQ-011 On rsp_valid & rsp_ready in RD_RESP:
- rsp_valid clears.
- If beats remain: ram_addr <= ram_addr+1, -> RD_ISSUE.
- Otherwise -> IDLE.
REQ-012 Burst address arithmetic SHALL be 8-bit modulo 256 (0xFF wraps to 0x00).
REQ-013 rsp_last=1 only on the beat whose index equals the latched req_len.
REQ-014 A new request SHALL NOT be accepted in the same cycle a burst completes; req_ready rises the cycle after the FSM returns to IDLE.
REQ-015 req_* inputs SHALL be ignored outside IDLE.

Reset
REQ-016 While rst=1 at an edge:
- state <= IDLE.
- req_ready=0 during reset; 1 in the first cycle after reset deasserts.
- rsp_valid, rsp_last, ram_en, busy = 0.
- rsp_rdata, ram_addr, ram_wdata = 0x00.
REQ-017 Reset during any state SHALL abort the operation: no residual ram_en pulse, no response beat.

Configuration
REQ-018 With RAM_MASTER_BURST_EN defined, req_len SHALL be honoured per REQ-011/013.
REQ-019 Without RAM_MASTER_BURST_EN:
- req_len is ignored; every read is one beat with rsp_last=1.
- No burst counter is instantiated.

Structure
REQ-020 Package ram_master_pkg SHALL hold ADDR_W=8, DATA_W=8, LEN_W=4 and the state enum type.
REQ-021 The design SHALL be a single module with no sub-module; the burst beat counter and address incrementer are inline.

Verification
REQ-022 Write 0xA5 to 0x10: ram_en high exactly one cycle with ram_addr=0x10 and ram_wdata=0xA5; rsp_valid never rises.
REQ-023 Read 0x10 with RAM model holding 0xA5, rsp_ready=1: rsp_valid in the third cycle after the accept edge, rsp_rdata=0xA5, rsp_last=1.
REQ-024 Burst read (BURST_EN) at addr 0xFE, req_len=3: 4 beats from addresses 0xFE, 0xFF, 0x00, 0x01; rsp_last only on the 4th beat.
REQ-025 Backpressure: rsp_ready held 0 for 5 cycles: rsp_rdata and rsp_last stable; ram_addr unchanged; no extra RAM activity.
REQ-026 rst asserted in RD_RESP, and separately in WRITE: all outputs return to reset values next cycle; ram_en does not pulse; req_ready=1 one cycle after rst deasserts.
REQ-027 Without the macro, read with req_len=7: exactly one beat returned, rsp_last=1.
